// File: rtl/player_judge_if.sv
// Bundle of play-control, note, button and score signals between the note
// shift registers / button synchroniser and the judge.
interface player_judge_if #(
    parameter int LANES   = 3,
    parameter int SCORE_W = 16,
    parameter int COMBO_W = 8
);
    logic               enable;
    logic               clear_score;
    logic               beat;
    logic [LANES-1:0]   notes;
    logic [LANES-1:0]   player_input;
    logic               increase_score;
    logic               decrease_score;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;

    modport master (
        output enable, clear_score, beat, notes, player_input,
        input  increase_score, decrease_score, score, combo
    );

    modport slave (
        input  enable, clear_score, beat, notes, player_input,
        output increase_score, decrease_score, score, combo
    );
endinterface

// File: rtl/player_judge.sv
// Beat-window judge: collects button rises over one beat window, compares them
// with the note column latched at the window start, and keeps a saturating
// score plus a combo counter.
// Optional macro PLAYER_JUDGE_COMBO_BONUS_EN adds (combo >> COMBO_SHIFT) to
// the points of every hit.
module player_judge #(
    parameter int LANES        = 3,
    parameter int SCORE_W      = 16,
    parameter int COMBO_W      = 8,
    parameter int HIT_POINTS   = 1,
    parameter int MISS_PENALTY = 1,
    parameter int COMBO_SHIFT  = 2
) (
    input  logic           clk,
    input  logic           resetn,
    player_judge_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_t;

    localparam logic [SCORE_W-1:0] HIT_PTS  = SCORE_W'(HIT_POINTS);
    localparam logic [SCORE_W-1:0] MISS_PTS = SCORE_W'(MISS_PENALTY);

    state_t             state, state_next;
    logic [LANES-1:0]   col, col_next;
    logic [LANES-1:0]   mask, mask_next;
    logic [LANES-1:0]   prev, rise;
    logic               hit_p0, miss_p0;
    logic [SCORE_W-1:0] points_p0;
    logic               inc_p1, dec_p1;
    logic [SCORE_W-1:0] score_p1;
    logic [COMBO_W-1:0] combo_p1;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[SCORE_W] ? '0 : d[SCORE_W-1:0];
    endfunction

    function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] c);
        return (c == '1) ? c : c + COMBO_W'(1);
    endfunction

    assign rise = bus.player_input & ~prev;

`ifdef PLAYER_JUDGE_COMBO_BONUS_EN
    // Bonus uses the combo value before this hit increments it.
    assign points_p0 = sat_add(HIT_PTS, SCORE_W'(combo_p1 >> COMBO_SHIFT));
`else
    localparam int unused_combo_shift = COMBO_SHIFT;
    assign points_p0 = HIT_PTS;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next state, window column/mask update and judgement of the closing window.
    always_comb begin
        state_next = state;
        col_next   = col;
        mask_next  = mask | rise;
        hit_p0     = 1'b0;
        miss_p0    = 1'b0;
        if (!bus.enable) begin
            state_next = IDLE;
            col_next   = '0;
            mask_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = ARMED;
                    col_next   = '0;
                    mask_next  = '0;
                end
                ARMED: begin
                    if (bus.beat) begin
                        state_next = PLAY;
                        col_next   = bus.notes;
                        mask_next  = '0;
                    end
                end
                PLAY: begin
                    if (bus.beat) begin
                        // A rise on the beat cycle opens the new window.
                        col_next  = bus.notes;
                        mask_next = rise;
                        if (col != '0) begin
                            hit_p0  = (mask == col);
                            miss_p0 = (mask != col);
                        end else begin
                            miss_p0 = (mask != '0);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    col_next   = '0;
                    mask_next  = '0;
                end
            endcase
        end
    end

    // ---- stage p1: registered judgement pulses, score and combo ----
    // Window registers, edge-detect history, pulses and saturating counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev     <= '0;
            col      <= '0;
            mask     <= '0;
            inc_p1   <= 1'b0;
            dec_p1   <= 1'b0;
            score_p1 <= '0;
            combo_p1 <= '0;
        end else begin
            prev   <= bus.player_input;
            col    <= col_next;
            mask   <= mask_next;
            inc_p1 <= hit_p0;
            dec_p1 <= miss_p0;
            if (bus.clear_score) begin
                score_p1 <= '0;
                combo_p1 <= '0;
            end else if (hit_p0) begin
                score_p1 <= sat_add(score_p1, points_p0);
                combo_p1 <= sat_inc_combo(combo_p1);
            end else if (miss_p0) begin
                score_p1 <= sat_sub(score_p1, MISS_PTS);
                combo_p1 <= '0;
            end
        end
    end

    assign bus.increase_score = inc_p1;
    assign bus.decrease_score = dec_p1;
    assign bus.score          = score_p1;
    assign bus.combo          = combo_p1;

endmodule

// File: doc/player_judge.md
Name: player_judge

Overview:
- Parametrised, sequential successor to the combinational hit/miss scorer.
- Judges player button presses against the current note column over a full beat window, not a single cycle.
- Keeps a saturating score and a combo counter, and emits one-cycle increase/decrease pulses to the display and sound logic.
- Sits between the note shift registers (lowest bit of each lane), the button synchroniser and the score display.

Parameters:
- LANES, 3, number of note lanes / player buttons.
- SCORE_W, 16, score register width.
- COMBO_W, 8, combo counter width.
- HIT_POINTS, 1, base points per hit.
- MISS_PENALTY, 1, points subtracted per miss.
- COMBO_SHIFT, 2, combo bonus divisor exponent (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- enable  input  1  play active; low forces IDLE.
- clear_score  input  1  synchronous pulse; zeroes score and combo.
- beat  input  1  one-cycle pulse marking the cycle the note registers shift.
- notes  input  LANES  current note column, lowest bit of each lane register.
- player_input  input  LANES  synchronised button levels, active-high.
- increase_score  output  1  one-cycle pulse on a hit judgement.
- decrease_score  output  1  one-cycle pulse on a miss judgement.
- score  output  SCORE_W  accumulated score.
- combo  output  COMBO_W  consecutive hits.

Behaviour:
- Reset: all outputs 0, state IDLE, latched column 0, press mask 0, previous-input register 0.
- Edge detect: rise = player_input & ~prev. prev updates every cycle in every state. Held buttons count once per press.
- States:
  - IDLE → ARMED when enable=1.
  - ARMED → PLAY on beat. This beat latches notes into col and clears the mask. No judgement is made.
  - PLAY: on each beat, judge the closing window, latch the new col, and load the mask with that cycle's rise.
  - Any state → IDLE when enable=0. Mask and col clear; score and combo hold.
- Window ownership: a rise in a non-beat cycle ORs into the mask. A rise in the same cycle as beat belongs to the new window.
- Judgement, evaluated at a beat in PLAY, outputs registered and valid the next cycle:
  - col≠0 and mask==col → hit.
  - col≠0 and mask≠col (missed or extra lanes) → miss.
  - col==0 and mask≠0 → miss.
  - col==0 and mask==0 → no event, combo holds.
- Hit: increase_score=1 for one cycle; score += points, saturating at 2^SCORE_W−1; combo += 1, saturating at 2^COMBO_W−1.
- Miss: decrease_score=1 for one cycle; score −= MISS_PENALTY, floored at 0; combo=0.
- increase_score and decrease_score are never both high.
- clear_score has priority over a same-cycle judgement: score=0 and combo=0. The pulse for that judgement is still emitted.
- Arithmetic: use a SCORE_W+1-bit intermediate for the saturation checks.
- Latency: beat at cycle t → pulse, score and combo update visible at t+1.

Optional Feature:
- Macro: PLAYER_JUDGE_COMBO_BONUS_EN.
- Defined: hit points = HIT_POINTS + (combo >> COMBO_SHIFT), using the pre-increment combo value, with saturating add.
- Undefined: hit points = HIT_POINTS; no bonus logic is synthesised.

Test Plan (LANES=3, SCORE_W=16, COMBO_W=8, HIT_POINTS=1, MISS_PENALTY=1, COMBO_SHIFT=2):
1. Reset, enable=1, beat, then col=3'b101; press lanes 0 and 2 mid-window, then beat → increase_score pulse one cycle after beat; score=1, combo=1.
2. col=3'b001, press lanes 0 and 1 → decrease_score pulse; score floors at 0 from 0; combo=0. Repeat with score=5 → score=4.
3. col=3'b000, no press → no pulse, score and combo unchanged. Same window with lane 2 pressed → miss.
4. Hold lane 0 across two windows, each with col=3'b001 → first window hit, second window miss (no new rise). Press on the beat cycle itself → counted in the next window.
5. Preload score=16'hFFFF via repeated hits (or force), then hit → score stays 16'hFFFF. With the macro defined and combo=8, a hit adds 3.
6. Drop enable mid-window after a press, re-enable, then first beat → no judgement (ARMED). Reset asserted mid-PLAY → all outputs 0 immediately. clear_score on a judging cycle → score=0, pulse still seen.
